// File: rtl/wb_arb_wdog_if.sv
// wb_arb_wdog_if: bundle of the arbiter's request/termination inputs and grant outputs.
//   req       : master cyc requests, bit n = master n
//   ack/err/rty : slave termination of the currently granted transfer
//   gnt       : granted master index
//   gnt_valid : bus owned by master gnt
//   abort     : one-cycle forced-error pulse for master gnt
//   to_cnt/to_mst : abort log, present only with WB_ARB_TO_LOG_EN defined
// Modports: master = requester/interconnect side, slave = arbiter side.
interface wb_arb_wdog_if #(
    parameter int unsigned NM = 8,
    parameter int unsigned GW = 3
);
    logic [NM-1:0] req;
    logic          ack;
    logic          err;
    logic          rty;
    logic [GW-1:0] gnt;
    logic          gnt_valid;
    logic          abort;
`ifdef WB_ARB_TO_LOG_EN
    logic [7:0]    to_cnt;
    logic [GW-1:0] to_mst;

    modport master (
        output req, ack, err, rty,
        input  gnt, gnt_valid, abort, to_cnt, to_mst
    );
    modport slave (
        input  req, ack, err, rty,
        output gnt, gnt_valid, abort, to_cnt, to_mst
    );
`else
    modport master (
        output req, ack, err, rty,
        input  gnt, gnt_valid, abort
    );
    modport slave (
        input  req, ack, err, rty,
        output gnt, gnt_valid, abort
    );
`endif
endinterface

// File: rtl/wb_arb_wdog.sv
// wb_arb_wdog: round-robin Wishbone cyc arbiter with a per-transfer watchdog.
// A grant is held while the owning master keeps cyc asserted. If the granted transfer
// sees no ack/err/rty for TO_CYCLES cycles, abort pulses for one cycle and the bus is
// reclaimed once the master drops cyc.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : wb_arb_wdog_if.slave -- req/ack/err/rty in; gnt/gnt_valid/abort out
//           (all outputs registered)
// Optional: define WB_ARB_TO_LOG_EN to add bus.to_cnt (saturating abort count) and
// bus.to_mst (index of the last aborted master).
module wb_arb_wdog #(
    parameter int unsigned NM        = 8,
    parameter int unsigned GW        = 3,
    parameter int unsigned TO_CYCLES = 255,
    parameter int unsigned TCW       = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    wb_arb_wdog_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StBusy, StAbort, StRelease} state_e;

    state_e         state_q, state_d;
    logic [GW-1:0]  gnt_q, gnt_d;
    logic [GW-1:0]  last_q, last_d;
    logic           gnt_valid_q, gnt_valid_d;
    logic           abort_q, abort_d;
    logic [TCW-1:0] wdog_q, wdog_d;

    logic [NM-1:0]  req_rot;
    logic           pick_found;
    logic [GW-1:0]  pick_idx;
    logic [GW:0]    pick_sum;
    logic           req_gnt;
    logic           term;

    assign term = bus.ack | bus.err | bus.rty;

    // Rotate requests so bit 0 is master last+1; the lowest set bit wins.
    always_comb begin
        req_rot    = NM'({bus.req, bus.req} >> (int'(last_q) + 1));
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_sum   = '0;
        for (int k = NM - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                pick_found = 1'b1;
                pick_sum   = {1'b0, last_q} + (GW + 1)'(k) + 1'b1;
                if (pick_sum >= (GW + 1)'(NM)) begin
                    pick_sum = pick_sum - (GW + 1)'(NM);
                end
                pick_idx = pick_sum[GW-1:0];
            end
        end
    end

    always_comb begin
        req_gnt = 1'b0;
        for (int i = 0; i < NM; i++) begin
            if (gnt_q == GW'(i)) begin
                req_gnt = bus.req[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        wdog_d  = wdog_q;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    state_d = StBusy;
                    gnt_d   = pick_idx;
                    last_d  = pick_idx;
                    wdog_d  = '0;
                end
            end
            StBusy: begin
                if (!req_gnt) begin
                    // Owner gone: hand over directly, or fall back to idle.
                    wdog_d = '0;
                    if (pick_found) begin
                        gnt_d  = pick_idx;
                        last_d = pick_idx;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (term) begin
                    // Termination on the limit cycle still wins over the abort.
                    wdog_d = '0;
                end else if (wdog_q == TCW'(TO_CYCLES - 1)) begin
                    state_d = StAbort;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            StAbort: begin
                wdog_d  = '0;
                state_d = StRelease;
            end
            StRelease: begin
                // Terminations are ignored here; only the owner dropping cyc matters.
                if (!req_gnt) begin
                    wdog_d = '0;
                    if (pick_found) begin
                        state_d = StBusy;
                        gnt_d   = pick_idx;
                        last_d  = pick_idx;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
        endcase
        gnt_valid_d = (state_d != StIdle);
        abort_d     = (state_d == StAbort);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            gnt_q       <= '0;
            last_q      <= GW'(NM - 1);
            gnt_valid_q <= 1'b0;
            abort_q     <= 1'b0;
            wdog_q      <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            gnt_valid_q <= gnt_valid_d;
            abort_q     <= abort_d;
            wdog_q      <= wdog_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.abort     = abort_q;

`ifdef WB_ARB_TO_LOG_EN
    logic [7:0]    to_cnt_q, to_cnt_d;
    logic [GW-1:0] to_mst_q, to_mst_d;

    // Updated on the edge that enters ABORT so the log is visible during the pulse.
    always_comb begin
        to_cnt_d = to_cnt_q;
        to_mst_d = to_mst_q;
        if (state_d == StAbort) begin
            if (to_cnt_q != 8'hFF) begin
                to_cnt_d = to_cnt_q + 8'd1;
            end
            to_mst_d = gnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
            to_mst_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
            to_mst_q <= to_mst_d;
        end
    end

    assign bus.to_cnt = to_cnt_q;
    assign bus.to_mst = to_mst_q;
`endif
endmodule
